// File: rtl/nes_input_controller_pkg.sv
// nes_input_controller_pkg: shared game-input constants, reader states and pad-to-button mapping
package nes_input_controller_pkg;
  localparam int BTN_UP = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_LEFT = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_ATTACK = 4;
  localparam int PRESS_OFS = 5;
  localparam int PAD_A = 0;
  localparam int PAD_B = 1;
  localparam int PAD_SELECT = 2;
  localparam int PAD_START = 3;
  localparam int PAD_UP = 4;
  localparam int PAD_DOWN = 5;
  localparam int PAD_LEFT = 6;
  localparam int PAD_RIGHT = 7;
  typedef enum logic [1:0] {IDLE, LATCH, READ, DONE} rd_state_t;
  function automatic logic [4:0] pad_to_buttons(input logic [7:0] pad);
    logic [4:0] b;
    b[BTN_UP] = ~pad[PAD_UP];
    b[BTN_DOWN] = ~pad[PAD_DOWN];
    b[BTN_LEFT] = ~pad[PAD_LEFT];
    b[BTN_RIGHT] = ~pad[PAD_RIGHT];
    b[BTN_ATTACK] = ~pad[PAD_A];
    return b;
  endfunction
endpackage

// File: rtl/nes_shift_reader.sv
// nes_shift_reader: drives the pad latch/clock strobes and shifts in the eight raw pad bits
module nes_shift_reader
  import nes_input_controller_pkg::*;
#(
  parameter int HALF_BIT = 150
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       data,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  output logic [7:0] raw,
  output logic       valid
);
  localparam int CW = $clog2(2 * HALF_BIT);
  localparam logic [CW-1:0] LATCH_END = CW'(2 * HALF_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  rd_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic phase, phase_n;
  logic [7:0] raw_n;
  assign ctrl_latch = state == LATCH;
  assign ctrl_clk = state == READ && phase;
  assign valid = state == DONE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      phase <= 1'b0;
      raw <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_idx_n;
      phase <= phase_n;
      raw <= raw_n;
    end
  // phase 0 is the low half that ends with a sample; phase 1 is the ctrl_clk high half
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    bit_idx_n = bit_idx;
    phase_n = phase;
    raw_n = raw;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) state_n = LATCH;
      end
      LATCH:
        if (cnt == LATCH_END) begin
          state_n = READ;
          cnt_n = '0;
          bit_idx_n = '0;
          phase_n = 1'b0;
        end
      READ:
        if (cnt == HALF_END) begin
          cnt_n = '0;
          if (phase) begin
            phase_n = 1'b0;
            bit_idx_n = bit_idx + 1'b1;
          end else begin
            raw_n[bit_idx] = data;
            if (bit_idx == 3'd7) state_n = DONE;
            else phase_n = 1'b1;
          end
        end
      default: begin
        cnt_n = '0;
        state_n = IDLE;
      end
    endcase
  end
endmodule

// File: rtl/nes_input_controller.sv
// nes_input_controller: polls a NES pad, debounces five game buttons and emits press/release pulses
module nes_input_controller
  import nes_input_controller_pkg::*;
#(
  parameter int HALF_BIT = 150,
  parameter int POLL_PERIOD = 416667,
  parameter int DEBOUNCE_POLLS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ctrl_data,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  output logic [9:0] input_data,
  output logic [4:0] buttons,
  output logic       poll_done
);
  localparam int PW = $clog2(POLL_PERIOD);
  localparam int MW = $clog2(DEBOUNCE_POLLS + 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE_POLLS);
  logic [PW-1:0] poll_cnt;
  logic poll_tick;
  logic [1:0] sync;
  logic [7:0] pad_raw;
  logic [4:0] raw, prev_raw, buttons_n;
  logic [MW-1:0] match_cnt, match_n;
  assign poll_tick = poll_cnt == PW'(POLL_PERIOD - 1);
  assign raw = pad_to_buttons(pad_raw);
  nes_shift_reader #(.HALF_BIT(HALF_BIT)) u_reader (
    .clk(clk),
    .reset(reset),
    .start(poll_tick),
    .data(sync[1]),
    .ctrl_latch(ctrl_latch),
    .ctrl_clk(ctrl_clk),
    .raw(pad_raw),
    .valid(poll_done)
  );
  always_comb begin
    match_n = raw != prev_raw ? MW'(1) : match_cnt == MATCH_MAX ? match_cnt : match_cnt + 1'b1;
    buttons_n = match_n == MATCH_MAX ? raw : buttons;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      poll_cnt <= '0;
      sync <= 2'b11;
      prev_raw <= '0;
      match_cnt <= '0;
      buttons <= '0;
      input_data <= '0;
    end else begin
      poll_cnt <= poll_tick ? '0 : poll_cnt + 1'b1;
      sync <= {sync[0], ctrl_data};
      input_data <= '0;
      if (poll_done) begin
        prev_raw <= raw;
        match_cnt <= match_n;
        buttons <= buttons_n;
        input_data[PRESS_OFS+:5] <= buttons_n & ~buttons;
        input_data[PRESS_OFS-1:0] <= ~buttons_n & buttons;
      end
    end
endmodule
